alu_op_decode_stage: RTL and testbench

//  Registered RV32I decode stage that drives the ALU: turns a fetched instruction into the 6-bit ALU op code,

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_op_decode_comb.sv | 164 ++++++++++++++++
 rtl/alu_op_decode_stage.sv | 99 +++++++++
 tb/tb_alu_op_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, opcodes, operand selects and decode bundle
//
// Purpose: common types for the ALU and the decode stage that feeds it.
// Contents:
//   alu_op_e  6-bit ALU operation code
//   a_sel_e   operand A source select
//   OP..STORE RV32I major opcodes (instr[6:0])
//   decode_t  decoded instruction bundle handed from decode to execute
package alu_pkg;

  typedef enum logic [5:0] {
    ALU_NONE   = 6'd0,
    ALU_ADD    = 6'd1,
    ALU_SLL    = 6'd2,
    ALU_SLT    = 6'd3,
    ALU_SLTU   = 6'd4,
    ALU_XOR    = 6'd5,
    ALU_SRL    = 6'd6,
    ALU_SRA    = 6'd7,
    ALU_OR     = 6'd8,
    ALU_AND    = 6'd9,
    ALU_SUB    = 6'd10,
    ALU_BEQ    = 6'd11,
    ALU_BNE    = 6'd12,
    ALU_BLT    = 6'd13,
    ALU_BGE    = 6'd14,
    ALU_BLTU   = 6'd15,
    ALU_BGEU   = 6'd16,
    ALU_PASS_A = 6'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_PC4  = 2'b10,
    A_ZERO = 2'b11
  } a_sel_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef struct packed {
    alu_op_e     alu_op;
    a_sel_e      a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic        is_jump;
    logic        mem_re;
    logic        mem_we;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// rtl/alu_op_decode_comb.sv - combinational RV32I instruction to ALU bundle decoder
//
// Purpose: pure combinational decode of one instruction word into a decode_t bundle.
// Ports:
//   i_instr  in  32  instruction word
//   o_dec    out     decoded bundle (alu_pkg::decode_t)
module alu_op_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output decode_t     o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_sh;
  alu_op_e     w_base_op;
  logic        w_legal;
  decode_t     w_dec;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'h000};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  // Shift-immediate forms carry only the shamt; funct7 bits are not part of the operand.
  assign w_imm_sh = {27'd0, i_instr[24:20]};

  // funct3 -> operation for OP / OP-IMM when funct7[5] is clear
  always_comb begin
    w_base_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_base_op = ALU_ADD;
      3'b001:  w_base_op = ALU_SLL;
      3'b010:  w_base_op = ALU_SLT;
      3'b011:  w_base_op = ALU_SLTU;
      3'b100:  w_base_op = ALU_XOR;
      3'b101:  w_base_op = ALU_SRL;
      3'b110:  w_base_op = ALU_OR;
      default: w_base_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_legal       = 1'b1;
    w_dec         = '0;
    w_dec.rs1     = i_instr[19:15];
    w_dec.rs2     = i_instr[24:20];
    w_dec.rd      = i_instr[11:7];
    // Opcode constants all end in 2'b11, so a non-32-bit encoding lands in default.
    case (w_opcode)
      OP: begin
        w_dec.rd_we = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          w_dec.alu_op = w_base_op;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_dec.alu_op = ALU_SUB;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
          w_dec.alu_op = ALU_SRA;
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_IMM: begin
        w_dec.rd_we  = 1'b1;
        w_dec.b_sel  = 1'b1;
        w_dec.imm    = w_imm_i;
        w_dec.alu_op = w_base_op;
        if (w_funct3 == 3'b001) begin
          w_dec.imm = w_imm_sh;
          if (w_funct7 != 7'b0000000) w_legal = 1'b0;
        end else if (w_funct3 == 3'b101) begin
          w_dec.imm = w_imm_sh;
          if (w_funct7 == 7'b0100000) w_dec.alu_op = ALU_SRA;
          else if (w_funct7 != 7'b0000000) w_legal = 1'b0;
        end
      end
      LUI: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.a_sel  = A_ZERO;
        w_dec.b_sel  = 1'b1;
        w_dec.imm    = w_imm_u;
        w_dec.rd_we  = 1'b1;
      end
      AUIPC: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.a_sel  = A_PC;
        w_dec.b_sel  = 1'b1;
        w_dec.imm    = w_imm_u;
        w_dec.rd_we  = 1'b1;
      end
      LOAD: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.b_sel  = 1'b1;
        w_dec.imm    = w_imm_i;
        w_dec.rd_we  = 1'b1;
        w_dec.mem_re = 1'b1;
        // LB/LH/LW/LBU/LHU only
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) w_legal = 1'b0;
      end
      STORE: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.b_sel  = 1'b1;
        w_dec.imm    = w_imm_s;
        w_dec.mem_we = 1'b1;
        if (w_funct3 > 3'b010) w_legal = 1'b0;
      end
      BRANCH: begin
        w_dec.is_branch = 1'b1;
        w_dec.imm       = w_imm_b;
        case (w_funct3)
          3'b000:  w_dec.alu_op = ALU_BEQ;
          3'b001:  w_dec.alu_op = ALU_BNE;
          3'b100:  w_dec.alu_op = ALU_BLT;
          3'b101:  w_dec.alu_op = ALU_BGE;
          3'b110:  w_dec.alu_op = ALU_BLTU;
          3'b111:  w_dec.alu_op = ALU_BGEU;
          default: w_legal = 1'b0;
        endcase
      end
      JAL: begin
        // ALU produces the link value PC+4; target uses imm separately.
        w_dec.alu_op  = ALU_PASS_A;
        w_dec.a_sel   = A_PC4;
        w_dec.b_sel   = 1'b1;
        w_dec.imm     = w_imm_j;
        w_dec.is_jump = 1'b1;
        w_dec.rd_we   = 1'b1;
      end
      JALR: begin
        w_dec.alu_op  = ALU_PASS_A;
        w_dec.a_sel   = A_PC4;
        w_dec.b_sel   = 1'b1;
        w_dec.imm     = w_imm_i;
        w_dec.is_jump = 1'b1;
        w_dec.rd_we   = 1'b1;
        if (w_funct3 != 3'b000) w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase

    // Illegal: keep only the raw register fields so nothing downstream can write or access memory.
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.rs1     = i_instr[19:15];
      w_dec.rs2     = i_instr[24:20];
      w_dec.rd      = i_instr[11:7];
      w_dec.illegal = 1'b1;
    end
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/alu_op_decode_stage.sv
// rtl/alu_op_decode_stage.sv - registered RV32I decode stage feeding the ALU
//
// Purpose: one-entry pipeline register between fetch and execute holding the decoded bundle,
//          with valid/ready on both sides, flush, and a saturating illegal-instruction counter.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i                       drop held and incoming instruction
//   in_valid_i/in_ready_o         fetch-side handshake; instr_i, pc_i payload
//   out_valid_o/out_ready_i       execute-side handshake
//   alu_op_o, op_a_sel_o, op_b_sel_o, imm_o, rs1/rs2/rd_addr_o, rd_we_o,
//   is_branch_o, is_jump_o, mem_re_o, mem_we_o, pc_o, illegal_o   decoded bundle
//   illegal_cnt_o                 saturating count of accepted illegal instructions
module alu_op_decode_stage
  import alu_pkg::*;
#(
  parameter int          CNT_W    = 8,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [5:0]       alu_op_o,
  output logic [1:0]       op_a_sel_o,
  output logic             op_b_sel_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_we_o,
  output logic             is_branch_o,
  output logic             is_jump_o,
  output logic             mem_re_o,
  output logic             mem_we_o,
  output logic [31:0]      pc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  decode_t          w_dec;
  logic             w_accept;
  logic             r_valid;
  decode_t          r_bundle;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;

  alu_op_decode_comb u_decode (
    .i_instr (instr_i),
    .o_dec   (w_dec)
  );

  assign in_ready_o = !r_valid | out_ready_i;
  // A flushed cycle neither captures nor counts the presented instruction.
  assign w_accept   = in_valid_i & in_ready_o & !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
      r_pc     <= PC_RESET;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_bundle <= w_dec;
      r_pc     <= pc_i;
      if (w_dec.illegal && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o   = r_valid;
  assign alu_op_o      = r_bundle.alu_op;
  assign op_a_sel_o    = r_bundle.a_sel;
  assign op_b_sel_o    = r_bundle.b_sel;
  assign imm_o         = r_bundle.imm;
  assign rs1_addr_o    = r_bundle.rs1;
  assign rs2_addr_o    = r_bundle.rs2;
  assign rd_addr_o     = r_bundle.rd;
  assign rd_we_o       = r_bundle.rd_we;
  assign is_branch_o   = r_bundle.is_branch;
  assign is_jump_o     = r_bundle.is_jump;
  assign mem_re_o      = r_bundle.mem_re;
  assign mem_we_o      = r_bundle.mem_we;
  assign illegal_o     = r_bundle.illegal;
  assign pc_o          = r_pc;
  assign illegal_cnt_o = r_cnt;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// tb/tb_alu_op_decode_stage.sv - self-checking bench for alu_op_decode_stage
module tb_alu_op_decode_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  a;
    logic        b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        jp;
    logic        re;
    logic        wm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  alu_op;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_we, is_branch, is_jump, mem_re, mem_we, illegal;
  logic [31:0] pc_out;
  logic [7:0]  cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_op_decode_stage #(.CNT_W(8), .PC_RESET(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_op_o(alu_op), .op_a_sel_o(a_sel), .op_b_sel_o(b_sel), .imm_o(imm),
    .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd),
    .rd_we_o(rd_we), .is_branch_o(is_branch), .is_jump_o(is_jump),
    .mem_re_o(mem_re), .mem_we_o(mem_we),
    .pc_o(pc_out), .illegal_o(illegal), .illegal_cnt_o(cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules with integer arithmetic.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    bit   ok;
    int   f3, f7, iimm, simm, bimm, jimm;
    int   ops[8] = '{1, 2, 3, 4, 5, 6, 8, 9};
    int   brs[8] = '{11, 12, 0, 0, 13, 14, 15, 16};
    e    = '0;
    ok   = 1;
    f3   = int'(w[14:12]);
    f7   = int'(w[31:25]);
    iimm = int'($signed(w)) >>> 20;
    simm = (int'($signed(w)) >>> 25) * 32 + int'(w[11:7]);
    bimm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    jimm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    case (w[6:0])
      7'h33: begin
        e.we = 1;
        if (f7 == 0) e.op = 6'(ops[f3]);
        else if (f7 == 32 && f3 == 0) e.op = 10;
        else if (f7 == 32 && f3 == 5) e.op = 7;
        else ok = 0;
      end
      7'h13: begin
        e.we = 1; e.b = 1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(int'(w[24:20]));
          if (f7 == 0) e.op = 6'(ops[f3]);
          else if (f7 == 32 && f3 == 5) e.op = 7;
          else ok = 0;
        end else begin
          e.imm = 32'(iimm);
          e.op  = 6'(ops[f3]);
        end
      end
      7'h37: begin e.op = 1; e.a = 3; e.b = 1; e.we = 1; e.imm = {w[31:12], 12'h0}; end
      7'h17: begin e.op = 1; e.a = 1; e.b = 1; e.we = 1; e.imm = {w[31:12], 12'h0}; end
      7'h03: begin
        e.op = 1; e.b = 1; e.we = 1; e.re = 1; e.imm = 32'(iimm);
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin e.op = 1; e.b = 1; e.wm = 1; e.imm = 32'(simm); ok = (f3 <= 2); end
      7'h63: begin
        e.br = 1; e.imm = 32'(bimm);
        if (brs[f3] == 0) ok = 0; else e.op = 6'(brs[f3]);
      end
      7'h6F: begin e.op = 17; e.a = 2; e.b = 1; e.jp = 1; e.we = 1; e.imm = 32'(jimm); end
      7'h67: begin e.op = 17; e.a = 2; e.b = 1; e.jp = 1; e.we = 1; e.imm = 32'(iimm); ok = (f3 == 0); end
      default: ok = 0;
    endcase
    if (!ok) e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.ill = !ok;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 9) begin
      w[6:0] = opcs[sel];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  // Stage-level expectations: what execute should see after each edge.
  logic        m_valid = 1'b0;
  exp_t        m_b = '0;
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_b     <= '0;
      m_pc    <= 32'h0;
      m_cnt   <= 0;
    end else begin
      bit   take;
      exp_t e;
      take = in_valid && (!m_valid || out_ready) && !flush;
      e    = model(instr);
      m_valid <= flush ? 1'b0 : (take ? 1'b1 : (m_valid && !out_ready));
      if (take) begin
        m_b   <= e;
        m_pc  <= pc;
        m_cnt <= (m_cnt + int'(e.ill) > 255) ? 255 : m_cnt + int'(e.ill);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_out_valid", 64'(out_valid), 64'(m_valid));
      chk("cmp_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("cmp_cnt", 64'(cnt), 64'(m_cnt));
      if (m_valid) begin
        chk("cmp_bundle", 64'({alu_op, a_sel, b_sel, imm, rs1, rs2, rd, rd_we, is_branch,
                               is_jump, mem_re, mem_we, illegal}), 64'(m_b));
        chk("cmp_pc", 64'(pc_out), 64'(m_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    in_valid  = v;
    instr     = i;
    pc        = p;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_pc"}, 64'(pc_out), 64'd0);
    chk({tag, "_bundle"}, 64'({alu_op, a_sel, b_sel, imm, rs1, rs2, rd, rd_we, is_branch,
                               is_jump, mem_re, mem_we, illegal}), 64'd0);
  endtask

  initial begin
    exp_t pin;
    #3;
    check_reset_state("reset");
    #9 rst_n = 1'b1;

    pin = model(32'hFE208EE3);
    chk("model_beq_imm", 64'(pin.imm), 64'hFFFFFFFC);
    pin = model(32'h008000EF);
    chk("model_jal_imm", 64'(pin.imm), 64'd8);

    tick();
    drive(1, 32'h002081B3, 32'h0, 1, 0);
    tick();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_op", 64'(alu_op), 64'd1);
    chk("add_sel", 64'({a_sel, b_sel}), 64'd0);
    chk("add_we_rd", 64'({rd_we, rd}), 64'h23);

    drive(1, 32'h40335293, 32'h4, 1, 0);
    tick();
    chk("srai_op", 64'(alu_op), 64'd7);
    chk("srai_bsel_imm", 64'({b_sel, imm}), 64'h1_0000_0003);
    chk("srai_ill", 64'(illegal), 64'd0);

    drive(1, 32'h20335293, 32'h8, 1, 0);
    tick();
    chk("srai_bad_ill", 64'({illegal, alu_op, rd_we}), 64'h80);
    chk("srai_bad_cnt", 64'(cnt), 64'd1);

    drive(1, 32'hFE208EE3, 32'hC, 1, 0);
    tick();
    chk("beq_op", 64'(alu_op), 64'd11);
    chk("beq_flags", 64'({is_branch, rd_we}), 64'h2);
    chk("beq_imm", 64'(imm), 64'hFFFFFFFC);

    drive(1, 32'h008000EF, 32'h100, 1, 0);
    tick();
    chk("jal_op", 64'(alu_op), 64'd17);
    chk("jal_asel", 64'(a_sel), 64'd2);
    chk("jal_jump_imm", 64'({is_jump, imm}), 64'h1_0000_0008);
    chk("jal_pc", 64'(pc_out), 64'h100);

    // Back-pressure: hold execute stalled while fetch keeps offering
    drive(1, 32'h00100093, 32'h200, 1, 0);
    tick();
    drive(1, 32'h00000093, 32'h204, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_pc", 64'({out_valid, pc_out}), 64'h1_0000_0200);
      chk("bp_hold_imm", 64'(imm), 64'd1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h00000093 | (32'(k) << 20), 32'h204 + 32'(4 * k), 1, 0);
      tick();
      chk("stream_pc", 64'({out_valid, pc_out}), 64'h1_0000_0000 | 64'(32'h204 + 32'(4 * k)));
      chk("stream_imm", 64'(imm), 64'(k));
    end

    drive(1, 32'hFFFFFFFF, 32'h300, 0, 1);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_cnt", 64'(cnt), 64'd1);
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();

    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) < 7), rand_instr(), $urandom,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      tick();
    end

    // Async reset mid-cycle while traffic is flowing
    drive(1, 32'h002081B3, 32'h400, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    #3 rst_n = 1'b1;

    drive(1, 32'hFFFFFFFF, 32'h500, 1, 0);
    for (int n = 0; n < 300; n++) tick();
    chk("sat_cnt", 64'(cnt), 64'd255);
    chk("sat_ill", 64'(illegal), 64'd1);

    rst_n = 1'b0;
    #1;
    check_reset_state("satreset");
    #3 rst_n = 1'b1;
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
